// File: rtl/tpu_pkg.sv
// Shared TPU datapath definitions: default element width / matrix size,
// loader FSM state encoding and the skewed drain length helper.
package tpu_pkg;

  localparam int BITS_AB_DEFAULT = 8;
  localparam int DIM_DEFAULT     = 8;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DRAIN,
    DONE
  } loader_state_t;

  // A DIM-wide skewed array needs 2*DIM-1 shifts to empty completely.
  function automatic int drain_cycles(input int dim);
    return 2 * dim - 1;
  endfunction

endpackage

// File: rtl/mema_loader_if.sv
// Stream-in handshake and memA write/shift bus of the memA loader.
// In_last is present only when MEMA_LOADER_LAST_CHECK_EN is defined.
interface mema_loader_if
  import tpu_pkg::*;
#(
  parameter int BITS_AB = BITS_AB_DEFAULT,
  parameter int DIM     = DIM_DEFAULT
) ();

  logic                       in_valid;
  logic                       in_ready;
  logic signed [BITS_AB-1:0]  in_data;
`ifdef MEMA_LOADER_LAST_CHECK_EN
  logic                       in_last;
`endif
  logic                       WrEn;
  logic [$clog2(DIM)-1:0]     Arow;
  logic signed [BITS_AB-1:0]  Ain [DIM];
  logic                       en;

`ifdef MEMA_LOADER_LAST_CHECK_EN
  modport master (
    input  in_valid, in_data, in_last,
    output in_ready, WrEn, Arow, Ain, en
  );

  modport slave (
    output in_valid, in_data, in_last,
    input  in_ready, WrEn, Arow, Ain, en
  );
`else
  modport master (
    input  in_valid, in_data,
    output in_ready, WrEn, Arow, Ain, en
  );

  modport slave (
    output in_valid, in_data,
    input  in_ready, WrEn, Arow, Ain, en
  );
`endif

endinterface

// File: rtl/mema_loader_row_assembler.sv
// Collects DIM accepted elements into row_buf and publishes each completed
// row through its own output register with a one-cycle row_done pulse.
module row_assembler
  import tpu_pkg::*;
#(
  parameter int BITS_AB = BITS_AB_DEFAULT,
  parameter int DIM     = DIM_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      accept,
  input  logic signed [BITS_AB-1:0] data,
  output logic                      row_last,
  output logic                      row_done,
  output logic signed [BITS_AB-1:0] row_out [DIM]
);

  localparam int CW = $clog2(DIM);
  localparam logic [CW-1:0] LAST_COL = CW'(DIM - 1);

  logic [CW-1:0]             col_cnt;
  logic signed [BITS_AB-1:0] row_buf [DIM];

  assign row_last = accept && (col_cnt == LAST_COL);

  // The final element bypasses row_buf so the row is published one cycle
  // after its last accept while row_buf is already refilling.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_cnt  <= '0;
      row_done <= 1'b0;
      for (int i = 0; i < DIM; i++) begin
        row_buf[i] <= '0;
        row_out[i] <= '0;
      end
    end else begin
      row_done <= 1'b0;
      if (clear) begin
        col_cnt <= '0;
      end else if (accept) begin
        row_buf[col_cnt] <= data;
        if (row_last) begin
          col_cnt  <= '0;
          row_done <= 1'b1;
          for (int i = 0; i < DIM; i++) begin
            row_out[i] <= (i == DIM - 1) ? data : row_buf[i];
          end
        end else begin
          col_cnt <= col_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mema_loader.sv
// memA front-end loader: assembles a row-major A stream into rows, writes
// them into memA, then runs the skewed drain. Optional MEMA_LOADER_LAST_CHECK_EN
// adds in_last framing check with a sticky err flag.
module mema_loader
  import tpu_pkg::*;
#(
  parameter int BITS_AB = BITS_AB_DEFAULT,
  parameter int DIM     = DIM_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         stall,
  output logic         busy,
  output logic         done,
`ifdef MEMA_LOADER_LAST_CHECK_EN
  output logic         err,
`endif
  mema_loader_if.master bus
);

  localparam int RW = $clog2(DIM);
  localparam int DW = $clog2(2 * DIM);
  localparam logic [RW-1:0] LAST_ROW   = RW'(DIM - 1);
  localparam logic [DW-1:0] LAST_DRAIN = DW'(drain_cycles(DIM) - 1);

  loader_state_t             state, state_next;
  logic [RW-1:0]             row_cnt;
  logic [DW-1:0]             drain_cnt;
  logic                      settle;
  logic                      accept;
  logic                      load_start;
  logic                      row_last;
  logic                      row_done;
  logic                      en_c;
  logic signed [BITS_AB-1:0] row_out [DIM];

  assign bus.in_ready = (state == FILL);
  assign busy         = (state != IDLE);
  assign accept       = bus.in_valid && bus.in_ready;
  assign load_start   = (state == IDLE) && start;
  assign bus.WrEn     = row_done;
  assign bus.Ain      = row_out;
  assign bus.en       = en_c;

  row_assembler #(
    .BITS_AB (BITS_AB),
    .DIM     (DIM)
  ) u_row (
    .clk      (clk),
    .rst      (rst),
    .clear    (load_start),
    .accept   (accept),
    .data     (bus.in_data),
    .row_last (row_last),
    .row_done (row_done),
    .row_out  (row_out)
  );

  always_comb begin
    state_next = state;
    en_c       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = FILL;
      end
      FILL: begin
        if (row_last && (row_cnt == LAST_ROW)) state_next = DRAIN;
      end
      DRAIN: begin
        // The first DRAIN cycle overlaps the last row write, so memA must not shift yet.
        en_c = !settle && !stall;
        if (en_c && (drain_cnt == LAST_DRAIN)) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      row_cnt   <= '0;
      drain_cnt <= '0;
      settle    <= 1'b0;
      bus.Arow  <= '0;
    end else begin
      state  <= state_next;
      settle <= (state == FILL) && (state_next == DRAIN);
      if (load_start) begin
        row_cnt <= '0;
      end else if (row_last) begin
        bus.Arow <= row_cnt;
        row_cnt  <= (row_cnt == LAST_ROW) ? '0 : row_cnt + 1'b1;
      end
      if (state == IDLE) begin
        drain_cnt <= '0;
      end else if (en_c) begin
        drain_cnt <= drain_cnt + 1'b1;
      end
    end
  end

`ifdef MEMA_LOADER_LAST_CHECK_EN
  logic final_elem;

  assign final_elem = row_last && (row_cnt == LAST_ROW);

  // in_last must be asserted on exactly the DIM*DIM-th accepted element.
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (load_start) begin
      err <= 1'b0;
    end else if (accept && (bus.in_last != final_elem)) begin
      err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mema_loader.sv
// Self-checking bench for mema_loader: directed loads with a row scoreboard.
// Exercises the in_last/err check when MEMA_LOADER_LAST_CHECK_EN is defined.
module tb_mema_loader;
  import tpu_pkg::*;

  localparam int BITS_AB = 8;
  localparam int DIM     = 8;
  localparam int W       = BITS_AB * DIM;
  localparam int ELEMS   = DIM * DIM;
  localparam int DRAIN_N = 2 * DIM - 1;
  localparam int DONE_AT = ELEMS + 1 + DRAIN_N + 1;

  typedef struct {
    logic [2:0]   arow;
    logic [W-1:0] row;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic stall;
  logic busy;
  logic done;
`ifdef MEMA_LOADER_LAST_CHECK_EN
  logic err;
`endif

  int   tests_run    = 0;
  int   tests_failed = 0;
  int   cyc          = 0;
  int   start_cyc    = 0;
  int   wr_count     = 0;
  int   en_count     = 0;
  int   en_first     = 0;
  int   en_last      = 0;
  int   done_count   = 0;
  int   done_cyc     = 0;
  int   wr_cyc_q [$];
  exp_t exp_q [$];

  mema_loader_if #(.BITS_AB(BITS_AB), .DIM(DIM)) bus ();

  mema_loader #(
    .BITS_AB (BITS_AB),
    .DIM     (DIM)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .stall (stall),
    .busy  (busy),
    .done  (done),
`ifdef MEMA_LOADER_LAST_CHECK_EN
    .err   (err),
`endif
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic signed [BITS_AB-1:0] elem(input int mode, input int r, input int c);
    if (mode == 0) return BITS_AB'(r * DIM + c - 32);
    if (c == 0) return -8'sd128;
    if (c == DIM - 1) return 8'sd127;
    return BITS_AB'((r * DIM + c) * 37);
  endfunction

  function automatic logic [W-1:0] exp_row(input int mode, input int r);
    logic [W-1:0] v;
    v = '0;
    for (int c = 0; c < DIM; c++) v[c*BITS_AB +: BITS_AB] = elem(mode, r, c);
    return v;
  endfunction

  function automatic logic [W-1:0] packed_ain();
    logic [W-1:0] v;
    v = '0;
    for (int c = 0; c < DIM; c++) v[c*BITS_AB +: BITS_AB] = bus.Ain[c];
    return v;
  endfunction

  // Output monitor: pops the scoreboard on every memA write, tracks en/done timing.
  always @(negedge clk) begin
    if (bus.WrEn === 1'b1) begin
      wr_count++;
      wr_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        checkOutput("wr_unexpected", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("wr_arow", W'(bus.Arow), W'(e.arow));
        checkOutput("wr_ain", packed_ain(), e.row);
      end
    end
    if (bus.en === 1'b1) begin
      if (en_count == 0) en_first = cyc;
      en_last = cyc;
      en_count++;
    end
    if (done === 1'b1) begin
      done_count++;
      done_cyc = cyc;
    end
  end

  task automatic clearStats();
    wr_count = 0;
    en_count = 0;
    wr_cyc_q.delete();
  endtask

  task automatic applyStimulus(input int mode, input int n_elems, input bit gapped, input int last_idx);
    bit acc;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    start_cyc = cyc;
    for (int k = 0; k < n_elems; k++) begin
      int r;
      int c;
      r = k / DIM;
      c = k % DIM;
      if (gapped && (k % 2 == 1)) begin
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
      end
      bus.in_valid = 1'b1;
      bus.in_data  = elem(mode, r, c);
`ifdef MEMA_LOADER_LAST_CHECK_EN
      bus.in_last  = (k == last_idx);
`endif
      if (c == DIM - 1) exp_q.push_back('{arow: 3'(r), row: exp_row(mode, r)});
      acc = 1'b0;
      for (int t = 0; t < 8 && !acc; t++) begin
        @(negedge clk);
        acc = bus.in_ready;
        @(posedge clk); #1;
      end
      if (!acc) checkOutput("accept_timeout", 0, 1);
    end
    bus.in_valid = 1'b0;
`ifdef MEMA_LOADER_LAST_CHECK_EN
    bus.in_last  = 1'b0;
`endif
    if (last_idx < 0) $display("[TB] unused last index");
  endtask

  task automatic waitDone(input int budget);
    int prev;
    bit seen;
    prev = done_count;
    seen = 1'b0;
    for (int t = 0; t < budget && !seen; t++) begin
      @(posedge clk); #1;
      seen = (done_count > prev);
    end
    checkOutput("done_seen", W'(seen), 1);
  endtask

  initial begin
    rst          = 1'b1;
    start        = 1'b0;
    stall        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
`ifdef MEMA_LOADER_LAST_CHECK_EN
    bus.in_last  = 1'b0;
`endif

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_in_ready", W'(bus.in_ready), 0);
    checkOutput("reset_wren", W'(bus.WrEn), 0);
    checkOutput("reset_en", W'(bus.en), 0);
    checkOutput("reset_busy", W'(busy), 0);
    checkOutput("reset_done", W'(done), 0);
    checkOutput("reset_arow", W'(bus.Arow), 0);
    checkOutput("reset_ain", packed_ain(), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // in_valid without start is ignored
    bus.in_valid = 1'b1;
    bus.in_data  = 8'sd5;
    repeat (4) @(negedge clk);
    checkOutput("idle_in_ready", W'(bus.in_ready), 0);
    checkOutput("idle_busy", W'(busy), 0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    checkOutput("idle_wren_count", W'(wr_count), 0);

    // Full continuous load
    clearStats();
    applyStimulus(0, ELEMS, 1'b0, ELEMS - 1);
    waitDone(200);
    checkOutput("full_wr_count", W'(wr_count), W'(DIM));
    checkOutput("full_first_wr", W'(wr_cyc_q[0] - start_cyc), W'(DIM));
    checkOutput("full_wr_span", W'(wr_cyc_q[DIM-1] - wr_cyc_q[0]), W'((DIM - 1) * DIM));
    checkOutput("full_en_count", W'(en_count), W'(DRAIN_N));
    checkOutput("full_en_contig", W'(en_last - en_first), W'(DRAIN_N - 1));
    checkOutput("full_done_cycle", W'(done_cyc - start_cyc + 1), W'(DONE_AT));
    @(negedge clk);
    checkOutput("full_done_pulse", W'(done), 0);
    checkOutput("full_idle_busy", W'(busy), 0);

    // Gapped stream with extreme values
    clearStats();
    applyStimulus(1, ELEMS, 1'b1, ELEMS - 1);
    waitDone(400);
    checkOutput("gap_wr_count", W'(wr_count), W'(DIM));
    checkOutput("gap_en_count", W'(en_count), W'(DRAIN_N));

    // Stall for 3 cycles mid-drain
    clearStats();
    applyStimulus(0, ELEMS, 1'b0, ELEMS - 1);
    for (int t = 0; t < 100 && en_count < 4; t++) begin
      @(posedge clk); #1;
    end
    checkOutput("stall_reached_drain", W'(en_count >= 4), 1);
    stall = 1'b1;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      checkOutput("stall_en_low", W'(bus.en), 0);
      @(posedge clk); #1;
    end
    stall = 1'b0;
    waitDone(200);
    checkOutput("stall_en_count", W'(en_count), W'(DRAIN_N));
    checkOutput("stall_done_cycle", W'(done_cyc - start_cyc + 1), W'(DONE_AT + 3));

    // Reset after 20 accepted elements
    clearStats();
    applyStimulus(0, 20, 1'b0, ELEMS - 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midrst_busy", W'(busy), 0);
    checkOutput("midrst_in_ready", W'(bus.in_ready), 0);
    repeat (10) @(posedge clk);
    #1;
    checkOutput("midrst_wr_count", W'(wr_count), 2);
    checkOutput("midrst_en_count", W'(en_count), 0);
    checkOutput("midrst_queue", W'(exp_q.size()), 0);
    clearStats();
    applyStimulus(1, ELEMS, 1'b0, ELEMS - 1);
    waitDone(200);
    checkOutput("after_rst_wr_count", W'(wr_count), W'(DIM));

`ifdef MEMA_LOADER_LAST_CHECK_EN
    clearStats();
    applyStimulus(0, ELEMS, 1'b0, ELEMS - 1);
    waitDone(200);
    checkOutput("last_ok_err", W'(err), 0);
    clearStats();
    applyStimulus(0, ELEMS, 1'b0, 40);
    waitDone(200);
    checkOutput("last_early_err", W'(err), 1);
    checkOutput("last_early_wr_count", W'(wr_count), W'(DIM));
    repeat (5) @(posedge clk);
    #1;
    checkOutput("last_err_sticky", W'(err), 1);
    clearStats();
    applyStimulus(0, ELEMS, 1'b0, ELEMS - 1);
    waitDone(200);
    checkOutput("last_err_cleared", W'(err), 0);
`endif

    checkOutput("scoreboard_empty", W'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
